// File: rtl/input_debouncer_pkg.sv
// Shared constants for the input debouncer: the 32-bit input map and gamepad framing.
package input_pkg;

   localparam int N_INPUTS      = 32;
   localparam int DIR_BASE      = 0;
   localparam int GP1_BASE      = 8;
   localparam int GP2_BASE      = 20;
   localparam int GP_WIDTH      = 12;
   localparam int GP_FRAME_BITS = 24;

   // Bit offsets of each button inside a 12-bit gamepad field (MSB first on the wire)
   localparam int BTN_B      = 11;
   localparam int BTN_Y      = 10;
   localparam int BTN_SELECT = 9;
   localparam int BTN_START  = 8;
   localparam int BTN_UP     = 7;
   localparam int BTN_DOWN   = 6;
   localparam int BTN_LEFT   = 5;
   localparam int BTN_RIGHT  = 4;
   localparam int BTN_A      = 3;
   localparam int BTN_X      = 2;
   localparam int BTN_L      = 1;
   localparam int BTN_R      = 0;

   // Both gamepads read as disconnected (all ones), direct buttons released
   localparam logic [N_INPUTS-1:0]      HELD_RESET = 32'hFFFF_FF00;
   localparam logic [GP_FRAME_BITS-1:0] GP_IDLE    = 24'hFF_FFFF;

endpackage

// File: rtl/input_debouncer_if.sv
// Pin bundle between the raw button/PMOD inputs and the debounced outputs.
interface input_debouncer_if;
   import input_pkg::*;

   logic [7:0]          btn_raw;
   logic                gp_latch;
   logic                gp_clk;
   logic                gp_data;
   logic [N_INPUTS-1:0] held_down;
   logic [N_INPUTS-1:0] just_pressed;

   modport master (
      output btn_raw, gp_latch, gp_clk, gp_data,
      input  held_down, just_pressed
   );

   modport slave (
      input  btn_raw, gp_latch, gp_clk, gp_data,
      output held_down, just_pressed
   );

endinterface

// File: rtl/input_debouncer_gamepad_pmod_rx.sv
// Serial gamepad PMOD receiver: synchronises latch/clock/data, shifts in bits and
// hands a complete 24-bit frame to the debouncer with a one-cycle frame_ok.
module gamepad_pmod_rx
   import input_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     gp_latch,
   input  logic                     gp_clk,
   input  logic                     gp_data,
   output logic [GP_FRAME_BITS-1:0] frame,
   output logic                     frame_ok
);

   logic [2:0]               latch_sync;
   logic [2:0]               clk_sync;
   logic [1:0]               data_sync;
   logic [GP_FRAME_BITS-1:0] shift_reg;
   logic [4:0]               bit_cnt;
   logic                     latch_rise;
   logic                     clk_rise;

   assign latch_rise = latch_sync[1] & ~latch_sync[2];
   assign clk_rise   = clk_sync[1] & ~clk_sync[2];

   // Two-flop synchronisers; the third latch/clock flop only feeds edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         latch_sync <= '0;
         clk_sync   <= '0;
         data_sync  <= '0;
      end else begin
         latch_sync <= {latch_sync[1:0], gp_latch};
         clk_sync   <= {clk_sync[1:0], gp_clk};
         data_sync  <= {data_sync[0], gp_data};
      end
   end

   // Shift/count bits; a latch accepts the frame only at exactly 24 bits, and when a
   // latch and a shift edge coincide the shifted bit starts the next frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
         frame     <= GP_IDLE;
         frame_ok  <= 1'b0;
      end else begin
         frame_ok <= 1'b0;
         if (latch_rise && bit_cnt == 5'(GP_FRAME_BITS)) begin
            frame    <= shift_reg;
            frame_ok <= 1'b1;
         end
         if (clk_rise) begin
            shift_reg <= {shift_reg[GP_FRAME_BITS-2:0], data_sync[1]};
         end
         if (latch_rise) begin
            bit_cnt <= clk_rise ? 5'd1 : 5'd0;
         end else if (clk_rise && bit_cnt != 5'd31) begin
            bit_cnt <= bit_cnt + 5'd1;
         end
      end
   end

endmodule

// File: rtl/input_debouncer.sv
// Input debouncer: debounces 8 direct buttons and two serial gamepads on a shared
// sample tick, producing held_down levels and one-cycle just_pressed pulses.
module input_debouncer
   import input_pkg::*;
#(
   parameter int TICK_DIV   = 50000,
   parameter int GP_TIMEOUT = 16
) (
   input logic               clk,
   input logic               rst_n,
   input_debouncer_if.slave  bus
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int TW = $clog2(GP_TIMEOUT + 1);

   logic [7:0]               btn_meta;
   logic [7:0]               btn_sync;
   logic [PW-1:0]            prescaler;
   logic                     tick;
   logic [TW-1:0]            timeout_cnt;
   logic [GP_FRAME_BITS-1:0] gp_state;
   logic [GP_FRAME_BITS-1:0] rx_frame;
   logic                     rx_frame_ok;
   logic [N_INPUTS-1:0]      sample;
   logic [N_INPUTS-1:0]      hist0;
   logic [N_INPUTS-1:0]      hist1;
   logic [N_INPUTS-1:0]      stable;
   logic [N_INPUTS-1:0]      held_q;
   logic [N_INPUTS-1:0]      held_prev;
   logic [N_INPUTS-1:0]      pressed_q;

   gamepad_pmod_rx u_rx (
      .clk      (clk),
      .rst_n    (rst_n),
      .gp_latch (bus.gp_latch),
      .gp_clk   (bus.gp_clk),
      .gp_data  (bus.gp_data),
      .frame    (rx_frame),
      .frame_ok (rx_frame_ok)
   );

   assign tick   = (prescaler == PW'(TICK_DIV - 1));
   assign sample = {gp_state, btn_sync};
   assign stable = ~(sample ^ hist0) & ~(sample ^ hist1);

   assign bus.held_down    = held_q;
   assign bus.just_pressed = pressed_q;

   // Two-flop synchroniser for the direct buttons
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_meta <= '0;
         btn_sync <= '0;
      end else begin
         btn_meta <= bus.btn_raw;
         btn_sync <= btn_meta;
      end
   end

   // Free-running prescaler that sets the debounce sample rate
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
      end else if (tick) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + PW'(1);
      end
   end

   // Gamepad state: load accepted frames, fall back to disconnected after too many silent ticks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gp_state    <= GP_IDLE;
         timeout_cnt <= '0;
      end else if (rx_frame_ok) begin
         gp_state    <= rx_frame;
         timeout_cnt <= '0;
      end else if (tick && timeout_cnt != TW'(GP_TIMEOUT)) begin
         timeout_cnt <= timeout_cnt + TW'(1);
         if (timeout_cnt == TW'(GP_TIMEOUT - 1)) begin
            gp_state <= GP_IDLE;
         end
      end
   end

   // Per-bit debounce: a level is accepted after three equal samples on consecutive ticks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist0  <= HELD_RESET;
         hist1  <= HELD_RESET;
         held_q <= HELD_RESET;
      end else if (tick) begin
         hist1  <= hist0;
         hist0  <= sample;
         held_q <= (held_q & ~stable) | (sample & stable);
      end
   end

   // One-cycle press pulse, registered one cycle after held_down rises
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_prev <= HELD_RESET;
         pressed_q <= '0;
      end else begin
         held_prev <= held_q;
         pressed_q <= held_q & ~held_prev;
      end
   end

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: directed table, reset corner case and
// randomized stimulus against a tick-level reference model.
module tb_input_debouncer;
   import input_pkg::*;

   localparam int TICK_DIV   = 128;
   localparam int GP_TIMEOUT = 4;
   localparam int MID        = 16;
   localparam int N_TBL      = 25;
   localparam int N_RAND     = 40;

   typedef enum logic [1:0] {GP_NONE, GP_FULL, GP_SHORT} gp_mode_t;

   typedef struct {
      logic [7:0]  btn;
      gp_mode_t    mode;
      logic [23:0] frame;
      logic [31:0] exp_held;
      logic [31:0] exp_jp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int unsigned k;

   int   jp_cnt [32];
   int   jp_snap [32];
   int   multi_cnt;
   logic [31:0] jp_last;

   vec_t tbl [N_TBL];

   logic [31:0]  m_held;
   logic [31:0]  m_hist [$];
   logic [23:0]  m_gp;
   int           m_since;

   always #5 clk = ~clk;

   input_debouncer_if bus ();

   input_debouncer #(
      .TICK_DIV   (TICK_DIV),
      .GP_TIMEOUT (GP_TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Cycle count since reset release; k mod TICK_DIV tracks the sample-tick phase
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) k <= 0;
      else        k <= k + 1;
   end

   // Pulse monitor: counts press pulses per bit and any pulse lasting two cycles
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 32; i++) begin
            if (bus.just_pressed[i]) jp_cnt[i] <= jp_cnt[i] + 1;
         end
         multi_cnt <= multi_cnt + $countones(bus.just_pressed & jp_last);
         jp_last   <= bus.just_pressed;
      end else begin
         jp_last <= '0;
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic take_snapshot();
      for (int i = 0; i < 32; i++) jp_snap[i] = jp_cnt[i];
   endtask

   function automatic logic [31:0] jp_delta();
      logic [31:0] d;
      for (int i = 0; i < 32; i++) d[i] = (jp_cnt[i] != jp_snap[i]);
      return d;
   endfunction

   task automatic wait_phase(input int ph);
      do begin
         @(posedge clk);
         #1;
      end while ((k % TICK_DIV) != ph);
   endtask

   task automatic send_frame(input logic [23:0] frame, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         bus.gp_data = frame[i];
         bus.gp_clk  = 1'b0;
         @(posedge clk); #1;
         bus.gp_clk  = 1'b1;
         @(posedge clk); #1;
      end
      bus.gp_clk = 1'b0;
      @(posedge clk); #1;
      bus.gp_latch = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.gp_latch = 1'b0;
      bus.gp_data  = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] btn, input gp_mode_t mode, input logic [23:0] frame);
      bus.btn_raw = btn;
      case (mode)
         GP_FULL:  send_frame(frame, 24);
         GP_SHORT: send_frame(frame, 23);
         default:  ;
      endcase
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      bus.btn_raw  = '0;
      bus.gp_latch = 1'b0;
      bus.gp_clk   = 1'b0;
      bus.gp_data  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Reference model step for one sample tick: a bit's level is accepted once the
   // last three samples agree; the gamepad reads all-ones after GP_TIMEOUT silent ticks
   task automatic model_tick(input logic [7:0] btn, output logic [31:0] rose);
      logic [31:0] s;
      logic [31:0] nh;
      s  = {(m_since >= GP_TIMEOUT) ? 24'hFF_FFFF : m_gp, btn};
      nh = m_held;
      for (int i = 0; i < 32; i++) begin
         if (s[i] == m_hist[$][i] && s[i] == m_hist[$-1][i]) nh[i] = s[i];
      end
      rose    = nh & ~m_held;
      m_held  = nh;
      m_hist.push_back(s);
      if (m_since < GP_TIMEOUT) m_since++;
   endtask

   initial begin
      logic [7:0]  rbtn;
      logic [23:0] rframe;
      logic [31:0] rose;
      gp_mode_t    rmode;
      int          pick;

      tbl[0]  = '{8'h01, GP_NONE,  24'h000000, 32'hFFFF_FF00, 32'h0000_0000};
      tbl[1]  = '{8'h01, GP_NONE,  24'h000000, 32'hFFFF_FF00, 32'h0000_0000};
      tbl[2]  = '{8'h01, GP_NONE,  24'h000000, 32'hFFFF_FF01, 32'h0000_0001};
      tbl[3]  = '{8'h08, GP_NONE,  24'h000000, 32'hFFFF_FF01, 32'h0000_0000};
      tbl[4]  = '{8'h08, GP_NONE,  24'h000000, 32'hFFFF_FF01, 32'h0000_0000};
      tbl[5]  = '{8'h00, GP_NONE,  24'h000000, 32'hFFFF_FF00, 32'h0000_0000};
      tbl[6]  = '{8'h00, GP_NONE,  24'h000000, 32'hFFFF_FF00, 32'h0000_0000};
      tbl[7]  = '{8'h00, GP_FULL,  24'hFFFFF7, 32'hFFFF_FF00, 32'h0000_0000};
      tbl[8]  = '{8'h00, GP_FULL,  24'hFFFFF7, 32'hFFFF_FF00, 32'h0000_0000};
      tbl[9]  = '{8'h00, GP_FULL,  24'hFFFFF7, 32'hFFFF_F700, 32'h0000_0000};
      tbl[10] = '{8'h00, GP_FULL,  24'hFFFFFF, 32'hFFFF_F700, 32'h0000_0000};
      tbl[11] = '{8'h00, GP_FULL,  24'hFFFFFF, 32'hFFFF_F700, 32'h0000_0000};
      tbl[12] = '{8'h00, GP_FULL,  24'hFFFFFF, 32'hFFFF_FF00, 32'h0000_0800};
      tbl[13] = '{8'h00, GP_SHORT, 24'h000000, 32'hFFFF_FF00, 32'h0000_0000};
      tbl[14] = '{8'h00, GP_SHORT, 24'h000000, 32'hFFFF_FF00, 32'h0000_0000};
      tbl[15] = '{8'h00, GP_SHORT, 24'h000000, 32'hFFFF_FF00, 32'h0000_0000};
      tbl[16] = '{8'h00, GP_FULL,  24'h000FFF, 32'hFFFF_FF00, 32'h0000_0000};
      tbl[17] = '{8'h00, GP_FULL,  24'h000FFF, 32'hFFFF_FF00, 32'h0000_0000};
      tbl[18] = '{8'h00, GP_FULL,  24'h000FFF, 32'h000F_FF00, 32'h0000_0000};
      tbl[19] = '{8'h00, GP_NONE,  24'h000000, 32'h000F_FF00, 32'h0000_0000};
      tbl[20] = '{8'h00, GP_NONE,  24'h000000, 32'h000F_FF00, 32'h0000_0000};
      tbl[21] = '{8'h00, GP_NONE,  24'h000000, 32'h000F_FF00, 32'h0000_0000};
      tbl[22] = '{8'h00, GP_NONE,  24'h000000, 32'h000F_FF00, 32'h0000_0000};
      tbl[23] = '{8'h00, GP_NONE,  24'h000000, 32'h000F_FF00, 32'h0000_0000};
      tbl[24] = '{8'h00, GP_NONE,  24'h000000, 32'hFFFF_FF00, 32'hFFF0_0000};

      $display("[TB] start, gp1 A is bit %0d", GP1_BASE + BTN_A);

      // Reset values and the directed table
      do_reset();
      checkOutput("reset_held", bus.held_down, 32'hFFFF_FF00);
      checkOutput("reset_jp", bus.just_pressed, 32'h0);
      wait_phase(MID);
      take_snapshot();
      for (int r = 0; r < N_TBL; r++) begin
         applyStimulus(tbl[r].btn, tbl[r].mode, tbl[r].frame);
         wait_phase(MID);
         checkOutput($sformatf("tbl%0d_held", r), bus.held_down, tbl[r].exp_held);
         checkOutput($sformatf("tbl%0d_jp", r), jp_delta(), tbl[r].exp_jp);
         take_snapshot();
      end

      // Reset lands after a press is accepted but before its pulse cycle
      do_reset();
      wait_phase(MID);
      bus.btn_raw = 8'h04;
      do begin
         @(posedge clk);
         #1;
      end while (k != 3 * TICK_DIV);
      checkOutput("rstmid_held_bit2", {31'b0, bus.held_down[2]}, 32'h1);
      checkOutput("rstmid_jp_before", bus.just_pressed, 32'h0);
      take_snapshot();
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rstmid_held", bus.held_down, 32'hFFFF_FF00);
      checkOutput("rstmid_jp", bus.just_pressed, 32'h0);
      bus.btn_raw = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) wait_phase(MID);
      checkOutput("rstmid_no_pulse", jp_delta(), 32'h0);
      checkOutput("rstmid_held_after", bus.held_down, 32'hFFFF_FF00);

      // Randomized stimulus against the reference model
      do_reset();
      m_held  = 32'hFFFF_FF00;
      m_hist  = '{32'hFFFF_FF00, 32'hFFFF_FF00};
      m_gp    = 24'hFF_FFFF;
      m_since = 0;
      rbtn    = 8'h00;
      rframe  = 24'hFF_FFFF;
      wait_phase(MID);
      take_snapshot();
      for (int r = 0; r < N_RAND; r++) begin
         rbtn   = rbtn ^ 8'($urandom & $urandom);
         rframe = rframe ^ 24'($urandom & $urandom);
         pick   = int'($urandom_range(9));
         rmode  = (pick < 5) ? GP_FULL : (pick < 7) ? GP_SHORT : GP_NONE;
         applyStimulus(rbtn, rmode, rframe);
         if (rmode == GP_FULL) begin
            m_gp    = rframe;
            m_since = 0;
         end
         model_tick(rbtn, rose);
         wait_phase(MID);
         checkOutput($sformatf("rnd%0d_held", r), bus.held_down, m_held);
         checkOutput($sformatf("rnd%0d_jp", r), jp_delta(), rose);
         take_snapshot();
      end

      checkOutput("jp_single_cycle", 32'(multi_cnt), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
